crt_framebuffer: RTL and testbench

- Precomputes the 40x6 AoC 2022 Day 10 CRT image into an internal bitmap by executing the program from an external instruction ROM, then serves pixels to the VGA painting logic through a registered read port.
- Sits upstream of the painter in the top level.
- Removes the need to clock the solver from the gated, inverted pixel clock.
- Also produces the part-1 signal-strength sum.

---
 rtl/crt_framebuffer.sv | 183 ++++++++++++++++++
 tb/tb_crt_framebuffer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/crt_framebuffer.sv
// Runs the CRT program from an external ROM into an internal bitmap, then serves
// pixels through a registered read port and reports the signal-strength sum.
module crt_framebuffer #(
    parameter int ADDR_W = 8,
    parameter int COLS   = 40,
    parameter int ROWS   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [ADDR_W-1:0]  instr_addr,
    input  logic [9:0]         instr_data,
    output logic               busy,
    output logic               done,
    input  logic [5:0]         rd_x,
    input  logic [2:0]         rd_y,
    output logic               rd_pixel,
    output logic signed [31:0] signal_sum
);
    localparam int PIXELS = COLS * ROWS;
    localparam int CW     = $clog2(PIXELS + 2);
    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS + 1);
    localparam logic [CW-1:0] LAST_C = CW'(PIXELS);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_EXEC1, S_EXEC2, S_NEXT, S_DONE
    } state_t;

    state_t               state_reg, state_next;
    logic [ADDR_W-1:0]    addr_reg;
    logic [9:0]           instr_reg;
    logic signed [15:0]   x_reg;
    logic [CW-1:0]        c_reg;
    logic [COL_W-1:0]     col_reg;
    logic [ROW_W-1:0]     row_reg;
    logic signed [31:0]   sum_reg;
    logic                 rd_pixel_reg;

    logic run_init, crt_cycle, x_update, addr_inc;
    logic is_end, is_addx, checkpoint, pixel_lit;
    logic signed [15:0] col_ext, diff;
    logic signed [31:0] c_ext, x_ext, product;
    logic [COLS-1:0]    bitmap [ROWS];
    logic [COLS-1:0]    row_sel;
    logic               in_range;

    assign is_end  = instr_reg[9];
    assign is_addx = instr_reg[8] && !instr_reg[9];

    // Next-state and control strobes for the datapath
    always_comb begin
        state_next = state_reg;
        run_init   = 1'b0;
        crt_cycle  = 1'b0;
        x_update   = 1'b0;
        addr_inc   = 1'b0;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_FETCH;
                    run_init   = 1'b1;
                end
            end
            S_FETCH: state_next = S_WAIT;
            S_WAIT:  state_next = S_EXEC1;
            S_EXEC1: begin
                crt_cycle = 1'b1;
                // an addx whose first cycle draws the final pixel is abandoned
                if (is_addx && c_reg != LAST_C)
                    state_next = S_EXEC2;
                else
                    state_next = S_NEXT;
            end
            S_EXEC2: begin
                crt_cycle  = 1'b1;
                x_update   = 1'b1;
                state_next = S_NEXT;
            end
            S_NEXT: begin
                if (c_reg > LAST_C) begin
                    state_next = S_DONE;
                end else begin
                    addr_inc   = !is_end && (addr_reg != {ADDR_W{1'b1}});
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        checkpoint = 1'b0;
        case (c_reg)
            CW'(20), CW'(60), CW'(100), CW'(140), CW'(180), CW'(220): checkpoint = 1'b1;
            default: checkpoint = 1'b0;
        endcase
    end

    assign col_ext   = $signed({{(16 - COL_W){1'b0}}, col_reg});
    assign diff      = col_ext - x_reg;
    assign pixel_lit = (diff >= -16'sd1) && (diff <= 16'sd1);
    assign c_ext     = $signed({{(32 - CW){1'b0}}, c_reg});
    assign x_ext     = {{16{x_reg[15]}}, x_reg};
    assign product   = c_ext * x_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            addr_reg  <= '0;
            instr_reg <= '0;
            x_reg     <= 16'sd1;
            c_reg     <= CW'(1);
            col_reg   <= '0;
            row_reg   <= '0;
            sum_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (run_init) begin
                addr_reg <= '0;
                x_reg    <= 16'sd1;
                c_reg    <= CW'(1);
                col_reg  <= '0;
                row_reg  <= '0;
                sum_reg  <= '0;
            end
            if (state_reg == S_WAIT)
                instr_reg <= instr_data;
            if (crt_cycle) begin
                if (checkpoint)
                    sum_reg <= sum_reg + product;
                c_reg <= c_reg + CW'(1);
                if (col_reg == COL_W'(COLS - 1)) begin
                    col_reg <= '0;
                    row_reg <= row_reg + ROW_W'(1);
                end else begin
                    col_reg <= col_reg + COL_W'(1);
                end
            end
            if (x_update)
                x_reg <= x_reg + $signed({{8{instr_reg[7]}}, instr_reg[7:0]});
            if (addr_inc)
                addr_reg <= addr_reg + ADDR_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            logic [COLS-1:0] row_bits_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    row_bits_reg <= '0;
                else if (crt_cycle && row_reg == ROW_W'(gi))
                    row_bits_reg[col_reg] <= pixel_lit;
            end
            assign bitmap[gi] = row_bits_reg;
        end
    endgenerate

    // Row mux keeps out-of-range rows from indexing past the array
    always_comb begin
        row_sel = '0;
        for (int i = 0; i < ROWS; i++)
            if (rd_y == 3'(i))
                row_sel = bitmap[i];
    end

    assign in_range = (rd_x < 6'(COLS)) && (rd_y < 3'(ROWS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_pixel_reg <= 1'b0;
        else
            rd_pixel_reg <= done && in_range && row_sel[rd_x];
    end

    assign busy       = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign done       = (state_reg == S_DONE);
    assign instr_addr = addr_reg;
    assign rd_pixel   = rd_pixel_reg;
    assign signal_sum = sum_reg;
endmodule

// File: tb/tb_crt_framebuffer.sv
// Scoreboard bench for crt_framebuffer: pixel reads queue their expected value,
// a negedge monitor compares once the registered rd_pixel appears.
module tb_crt_framebuffer;
    localparam int ADDR_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [ADDR_W-1:0]  instr_addr;
    logic [9:0]         instr_data;
    logic               busy;
    logic               done;
    logic [5:0]         rd_x;
    logic [2:0]         rd_y;
    logic               rd_pixel;
    logic signed [31:0] signal_sum;

    crt_framebuffer #(.ADDR_W(ADDR_W), .COLS(40), .ROWS(6)) dut (
        .clk(clk), .rst(rst), .start(start),
        .instr_addr(instr_addr), .instr_data(instr_data),
        .busy(busy), .done(done),
        .rd_x(rd_x), .rd_y(rd_y), .rd_pixel(rd_pixel),
        .signal_sum(signal_sum)
    );

    always #5 clk = ~clk;

    logic [9:0] rom [256];
    always @(posedge clk) instr_data <= rom[instr_addr];

    // AoC example program: 0 encodes noop, anything else is addx of that value
    int aoc [146] = '{
        15, -11, 6, -3, 5, -1, -8, 13, 4, 0,
        -1, 5, -1, 5, -1, 5, -1, 5, -1, -35,
        1, 24, -19, 1, 16, -11, 0, 0, 21, -15,
        0, 0, -3, 9, 1, -3, 8, 1, 5, 0,
        0, 0, 0, 0, -36, 0, 1, 7, 0, 0,
        0, 2, 6, 0, 0, 0, 0, 0, 1, 0,
        0, 7, 1, 0, -13, 13, 7, 0, 1, -33,
        0, 0, 0, 2, 0, 0, 0, 8, 0, -1,
        2, 1, 0, 17, -9, 1, 1, -3, 11, 0,
        0, 1, 0, 1, 0, 0, -13, -19, 1, 3,
        26, -30, 12, -1, 3, 1, 0, 0, 0, -9,
        18, 1, 2, 0, 0, 9, 0, 0, 0, -1,
        2, -37, 1, 3, 0, 15, -21, 22, -6, 1,
        0, 2, 1, 0, -10, 0, 0, 20, 1, 2,
        2, -6, -11, 0, 0, 0
    };

    typedef struct { int x; int y; bit v; } pix_t;
    pix_t exp_q[$];
    logic issue   = 1'b0;
    logic issue_d = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end else begin
            $display("ok   %s = %0d", nm, act);
        end
    endtask

    always @(posedge clk) issue_d <= issue;

    always @(negedge clk) begin
        if (issue_d) begin
            pix_t e;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pix_underflow: got rd_pixel=%0d expected no output", rd_pixel);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("pix(%0d,%0d)", e.x, e.y), rd_pixel, e.v);
            end
        end
    end

    function automatic void push_exp(input int x, input int y, input bit v);
        pix_t e;
        e.x = x; e.y = y; e.v = v;
        exp_q.push_back(e);
    endfunction

    task automatic rd(input int x, input int y, input bit v);
        rd_x  = 6'(x);
        rd_y  = 3'(y);
        issue = 1'b1;
        push_exp(x, y, v);
        @(posedge clk); @(negedge clk);
        issue = 1'b0;
    endtask

    task automatic read_row(input int y, input string pat);
        for (int x = 0; x < 40; x++) begin
            byte ch;
            ch = pat[x];
            rd(x, y, ch == 8'h23);
        end
    endtask

    function automatic string mk_row(input int n);
        string s;
        s = "";
        for (int i = 0; i < 40; i++) begin
            if (i < n) s = {s, "#"};
            else       s = {s, "."};
        end
        return s;
    endfunction

    // Pulses start, optionally pokes start again mid-run, counts clocks to done
    task automatic run(input int poke, output int cyc);
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        check("done_fall", done, 0);
        check("busy_rise", busy, 1);
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = (cyc == poke);
            if (cyc == 2) begin
                rd_x  = 6'd0;
                rd_y  = 3'd0;
                issue = 1'b1;
                push_exp(0, 0, 1'b0);
            end else begin
                issue = 1'b0;
            end
        end
        start = 1'b0;
        issue = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 10'h000;
    endtask

    task automatic load_small();
        clear_rom();
        rom[0] = 10'h000;
        rom[1] = {2'b01, 8'sd3};
        rom[2] = {2'b01, -8'sd5};
        rom[3] = 10'h200;
    endtask

    task automatic check_small_image();
        read_row(0, mk_row(5));
        for (int y = 1; y < 6; y++) read_row(y, mk_row(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        rst   = 1'b1;
        start = 1'b0;
        rd_x  = 6'd0;
        rd_y  = 3'd0;
        clear_rom();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pixel", rd_pixel, 0);
        check("rst_sum", signal_sum, 0);
        check("rst_addr", instr_addr, 0);

        // reset asserted while the first addx is in its second cycle
        load_small();
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("mid_busy", busy, 1);
        check("mid_addr", instr_addr, 1);
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_addr", instr_addr, 0);
        check("arst_sum", signal_sum, 0);
        check("arst_pixel", rd_pixel, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run(-1, cyc);
        check("small_cycles", cyc, 954);
        check("small_sum", signal_sum, -720);
        check("small_busy", busy, 0);
        check("small_done", done, 1);
        check("small_addr", instr_addr, 3);
        check_small_image();

        // back-to-back reads with out-of-range coordinates
        rd(0, 0, 1'b1);
        rd(39, 5, 1'b0);
        rd(40, 0, 1'b0);
        rd(0, 6, 1'b0);
        rd(4, 0, 1'b1);
        rd(5, 0, 1'b0);
        rd(63, 7, 1'b0);
        rd(0, 5, 1'b1);

        // restart from done with a stray start mid-run
        run(100, cyc);
        check("restart_cycles", cyc, 954);
        check("restart_sum", signal_sum, -720);
        check("restart_addr", instr_addr, 3);
        check_small_image();

        clear_rom();
        rom[0] = 10'h200;
        run(-1, cyc);
        check("end_cycles", cyc, 960);
        check("end_sum", signal_sum, 720);
        check("end_addr", instr_addr, 0);
        for (int y = 0; y < 6; y++) read_row(y, mk_row(3));

        clear_rom();
        for (int i = 0; i < 146; i++)
            rom[i] = (aoc[i] == 0) ? 10'h000 : {2'b01, 8'(aoc[i])};
        rom[146] = 10'h200;
        run(-1, cyc);
        check("aoc_cycles", cyc, 678);
        check("aoc_sum", signal_sum, 13140);
        check("aoc_addr", instr_addr, 145);
        read_row(0, "##..##..##..##..##..##..##..##..##..##..");
        read_row(5, "#######.......#######.......#######.....");

        @(negedge clk); @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
